// File: rtl/itrx_amba4_apb_master.sv
`default_nettype none
// ============================================================================
// itrx_amba4_apb_master : APB4 requester, one valid/ready command per transfer
// Revision: 1.0
// ============================================================================
module itrx_amba4_apb_master #(
   parameter  int PDATAW  = 32,
   parameter  int NS      = 16,
   parameter  int SEL_LSB = 12,
   parameter  int TIMEOUT = 255,
   localparam int PSTRBW  = PDATAW / 8,
   localparam int SELW    = (NS > 1) ? $clog2(NS) : 1
) (
   input  logic                 pclk_i,
   input  logic                 preset_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_write_i,
   input  logic [31:0]          cmd_addr_i,
   input  logic [PDATAW-1:0]    cmd_wdata_i,
   input  logic [PSTRBW-1:0]    cmd_strb_i,
   input  logic [2:0]           cmd_prot_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [PDATAW-1:0]    rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic                 rsp_timeout_o,
   output logic [31:0]          paddr_o,
   output logic                 pwrite_o,
   output logic [PDATAW-1:0]    pwdata_o,
   output logic [PSTRBW-1:0]    pstrb_o,
   output logic [2:0]           pprot_o,
   output logic [NS-1:0]        psel_o,
   output logic                 penable_o,
   input  logic [NS*PDATAW-1:0] prdata_i,
   input  logic [NS-1:0]        pready_i,
   input  logic [NS-1:0]        pslverr_i
);

   localparam logic [1:0]      c_IDLE     = 2'd0;
   localparam logic [1:0]      c_SETUP    = 2'd1;
   localparam logic [1:0]      c_ACCESS   = 2'd2;
   localparam logic [1:0]      c_RESP     = 2'd3;
   localparam int              NSLOT      = 2 ** SELW;
   localparam logic [SELW:0]   c_NS_LIMIT = (SELW + 1)'(NS);
   localparam logic [15:0]     c_TMO_LAST = 16'(TIMEOUT - 1);

   logic [1:0]        state_q,  state_d;
   logic [SELW-1:0]   idx_q,    idx_d;
   logic [31:0]       paddr_q,  paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [PDATAW-1:0] pwdata_q, pwdata_d;
   logic [PSTRBW-1:0] pstrb_q,  pstrb_d;
   logic [2:0]        pprot_q,  pprot_d;
   logic [PDATAW-1:0] rdata_q,  rdata_d;
   logic              err_q,    err_d;
   logic              tmo_q,    tmo_d;
   logic [15:0]       cnt_q,    cnt_d;

   // Slave-side buses padded to a power of two so the index mux never runs off the end.
   logic [PDATAW-1:0] w_prdata [NSLOT];
   logic [NSLOT-1:0]  w_pready;
   logic [NSLOT-1:0]  w_pslverr;
   logic [SELW-1:0]   w_cmd_idx;
   logic              w_active;

   for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NS) begin : g_real
         assign w_prdata[gi]  = prdata_i[gi*PDATAW +: PDATAW];
         assign w_pready[gi]  = pready_i[gi];
         assign w_pslverr[gi] = pslverr_i[gi];
      end else begin : g_pad
         assign w_prdata[gi]  = '0;
         assign w_pready[gi]  = 1'b0;
         assign w_pslverr[gi] = 1'b0;
      end
   end

   assign w_cmd_idx = cmd_addr_i[SEL_LSB +: SELW];

   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state_q  <= c_IDLE;
         idx_q    <= '0;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         pprot_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         pstrb_q  <= pstrb_d;
         pprot_q  <= pprot_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      pprot_d  = pprot_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      tmo_d    = tmo_q;
      cnt_d    = cnt_q;
      case (state_q)
         c_IDLE: begin
            if (cmd_valid_i) begin
               if ({1'b0, w_cmd_idx} >= c_NS_LIMIT) begin
                  state_d = c_RESP;
                  rdata_d = '0;
                  err_d   = 1'b1;
                  tmo_d   = 1'b0;
               end else begin
                  state_d  = c_SETUP;
                  idx_d    = w_cmd_idx;
                  paddr_d  = cmd_addr_i;
                  pwrite_d = cmd_write_i;
                  pwdata_d = cmd_wdata_i;
                  pstrb_d  = cmd_write_i ? cmd_strb_i : '0;
                  pprot_d  = cmd_prot_i;
               end
            end
         end
         c_SETUP: begin
            state_d = c_ACCESS;
            cnt_d   = '0;
         end
         c_ACCESS: begin
            // pready wins over an expiring timeout in the same cycle.
            if (w_pready[idx_q]) begin
               state_d = c_RESP;
               rdata_d = pwrite_q ? '0 : w_prdata[idx_q];
               err_d   = w_pslverr[idx_q];
               tmo_d   = 1'b0;
            end else if (TIMEOUT != 0 && cnt_q == c_TMO_LAST) begin
               state_d = c_RESP;
               rdata_d = '0;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         c_RESP: begin
            if (rsp_ready_i) begin
               state_d = c_IDLE;
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o = (state_q == c_IDLE) && !preset_i;
      w_active    = (state_q == c_SETUP) || (state_q == c_ACCESS);
      penable_o   = (state_q == c_ACCESS);
      rsp_valid_o = (state_q == c_RESP);
      psel_o      = '0;
      for (int i = 0; i < NS; i++) begin
         psel_o[i] = w_active && (idx_q == SELW'(i));
      end
   end

   assign paddr_o       = paddr_q;
   assign pwrite_o      = pwrite_q;
   assign pwdata_o      = pwdata_q;
   assign pstrb_o       = pstrb_q;
   assign pprot_o       = pprot_q;
   assign rsp_rdata_o   = rdata_q;
   assign rsp_err_o     = err_q;
   assign rsp_timeout_o = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_itrx_amba4_apb_master.sv
`default_nettype none
// ============================================================================
// tb_itrx_amba4_apb_master : scoreboard bench with APB slave responder model
// Revision: 1.0
// ============================================================================
module tb_itrx_amba4_apb_master;

   localparam int NS_T = 6;
   localparam int TMO  = 8;
   localparam int DW   = 32;

   logic             pclk = 1'b0;
   logic             preset;
   logic             cmd_valid, cmd_ready, cmd_write;
   logic [31:0]      cmd_addr, cmd_wdata;
   logic [3:0]       cmd_strb;
   logic [2:0]       cmd_prot;
   logic             rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0]      rsp_rdata;
   logic [31:0]      paddr, pwdata;
   logic             pwrite, penable;
   logic [3:0]       pstrb;
   logic [2:0]       pprot;
   logic [NS_T-1:0]  psel;
   logic [NS_T*DW-1:0] prdata;
   logic [NS_T-1:0]  pready, pslverr;

   itrx_amba4_apb_master #(
      .PDATAW (DW),
      .NS     (NS_T),
      .SEL_LSB(12),
      .TIMEOUT(TMO)
   ) dut (
      .pclk_i       (pclk),
      .preset_i     (preset),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_write_i  (cmd_write),
      .cmd_addr_i   (cmd_addr),
      .cmd_wdata_i  (cmd_wdata),
      .cmd_strb_i   (cmd_strb),
      .cmd_prot_i   (cmd_prot),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_rdata_o  (rsp_rdata),
      .rsp_err_o    (rsp_err),
      .rsp_timeout_o(rsp_timeout),
      .paddr_o      (paddr),
      .pwrite_o     (pwrite),
      .pwdata_o     (pwdata),
      .pstrb_o      (pstrb),
      .pprot_o      (pprot),
      .psel_o       (psel),
      .penable_o    (penable),
      .prdata_i     (prdata),
      .pready_i     (pready),
      .pslverr_i    (pslverr)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      bit          tmo;
      int          lat;
      int          acc;
      int          acc_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   int   cyc    = 0;

   // Current command as seen by the slave responder and the APB checker.
   int          cur_idx   = 99;
   int          cur_wait  = 0;
   bit          cur_err   = 0;
   logic [31:0] cur_rdata = '0;
   logic [31:0] cur_addr  = '0;
   logic [31:0] cur_wdata = '0;
   logic [3:0]  cur_strb  = '0;
   logic [2:0]  cur_prot  = '0;
   bit          cur_write = 0;
   int          acc_cnt   = 0;
   int          last_acc  = 0;
   bit          rsp_hold  = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
   endtask

   // Slave responder: selected slave raises pready after cur_wait wait states.
   initial begin
      forever begin
         @(posedge pclk);
         #1;
         if (psel != 0 && penable) acc_cnt++;
         else begin
            if (acc_cnt > 0) last_acc = acc_cnt;
            acc_cnt = 0;
         end
         for (int s = 0; s < NS_T; s++) begin
            prdata[s*DW +: DW] = $urandom;
            pready[s]          = 1'($urandom % 2);
            pslverr[s]         = 1'($urandom % 2);
         end
         if (cur_idx < NS_T) begin
            prdata[cur_idx*DW +: DW] = cur_rdata;
            pready[cur_idx]          = (acc_cnt >= cur_wait + 1);
            pslverr[cur_idx]         = cur_err;
         end
      end
   end

   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge pclk);
         #1;
         rsp_ready = rsp_hold ? 1'b0 : ($urandom % 4 != 0);
      end
   end

   // APB-side checker.
   initial begin
      logic [NS_T-1:0] ep;
      forever begin
         @(negedge pclk);
         if (!preset) begin
            if (psel == 0) chk("penable_without_psel", penable, 0);
            else begin
               ep = '0;
               if (cur_idx < NS_T) ep[cur_idx] = 1'b1;
               chk("psel", psel, ep);
               chk("paddr", paddr, cur_addr);
               chk("pwrite", pwrite, cur_write);
               chk("pwdata", pwdata, cur_wdata);
               chk("pstrb", pstrb, cur_write ? cur_strb : 4'h0);
               chk("pprot", pprot, cur_prot);
            end
         end
      end
   end

   // Response monitor: pops the scoreboard on each rsp handshake.
   initial begin
      exp_t        e;
      bit          in_resp = 0;
      bit          pend    = 0;
      logic [31:0] pv_rdata;
      logic        pv_err, pv_tmo;
      forever begin
         @(negedge pclk);
         if (preset) begin
            in_resp = 0;
            pend    = 0;
         end else if (rsp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
            else begin
               e = exp_q[0];
               if (!in_resp) chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
               in_resp = 1;
               chk("cmd_ready_in_resp", cmd_ready, 0);
               if (pend) begin
                  chk("stable_rdata", rsp_rdata, pv_rdata);
                  chk("stable_err", rsp_err, pv_err);
                  chk("stable_timeout", rsp_timeout, pv_tmo);
               end
               if (rsp_ready) begin
                  chk("rsp_rdata", rsp_rdata, e.rdata);
                  chk("rsp_err", rsp_err, e.err);
                  chk("rsp_timeout", rsp_timeout, e.tmo);
                  chk("access_cycles", 64'(last_acc), 64'(e.acc));
                  void'(exp_q.pop_front());
                  in_resp = 0;
                  pend    = 0;
               end else begin
                  pend     = 1;
                  pv_rdata = rsp_rdata;
                  pv_err   = rsp_err;
                  pv_tmo   = rsp_timeout;
               end
            end
         end
      end
   end

   // Reference: decode error, timeout after TMO ACCESS cycles, else pready after w waits.
   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int w,
                        input bit se, input logic [31:0] rd, input bit want);
      exp_t e;
      int   n = 0;
      @(negedge pclk);
      while (!cmd_ready && n < 300) begin
         @(negedge pclk);
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_wait", cmd_ready, 1);
         return;
      end
      cur_idx   = int'((addr >> 12) & 32'h7);
      cur_addr  = addr;
      cur_write = wr;
      cur_wdata = wd;
      cur_strb  = st;
      cur_prot  = pr;
      cur_wait  = w;
      cur_err   = se;
      cur_rdata = rd;
      last_acc  = 0;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_strb  = st;
      cmd_prot  = pr;
      cmd_valid = 1'b1;
      e.acc_cyc = cyc;
      if (cur_idx >= NS_T) begin
         e.rdata = '0; e.err = 1; e.tmo = 0; e.lat = 1; e.acc = 0;
      end else if (w >= TMO) begin
         e.rdata = '0; e.err = 1; e.tmo = 1; e.lat = 2 + TMO; e.acc = TMO;
      end else begin
         e.rdata = wr ? 32'h0 : rd; e.err = se; e.tmo = 0; e.lat = 3 + w; e.acc = w + 1;
      end
      if (want) exp_q.push_back(e);
      @(posedge pclk);
      #1;
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_write = 1'($urandom);
      cmd_strb  = 4'($urandom);
      cmd_prot  = 3'($urandom);
   endtask

   initial begin
      int n;
      preset    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      cmd_prot  = '0;
      repeat (3) @(negedge pclk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_pstrb", pstrb, 0);
      chk("rst_pprot", pprot, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", {rsp_err, rsp_timeout}, 0);
      preset = 1'b0;
      @(negedge pclk);
      chk("cmd_ready_after_reset", cmd_ready, 1);

      issue(1, 32'h0000_2010, 32'hDEADBEEF, 4'hF, 3'b010, 0, 0, $urandom, 1);
      issue(0, 32'h0000_5004, $urandom, 4'hA, 3'b001, 3, 0, 32'h12345678, 1);
      issue(1, 32'h0000_1008, $urandom, 4'h3, 3'b000, 1, 1, $urandom, 1);
      issue(0, 32'h0000_3000, $urandom, 4'hF, 3'b100, 100, 0, $urandom, 1);
      issue(0, 32'h0000_6000, $urandom, 4'hF, 3'b000, 0, 0, $urandom, 1);
      issue(0, 32'h0000_4ABC, $urandom, 4'h5, 3'b011, TMO - 1, 1, 32'hA5A5_0F0F, 1);

      // Response back-pressure.
      issue(0, 32'h0000_0020, $urandom, 4'hF, 3'b000, 1, 0, 32'hCAFEF00D, 1);
      rsp_hold = 1;
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge pclk);
         n++;
      end
      chk("hold_rsp_seen", rsp_valid, 1);
      repeat (5) @(negedge pclk);
      rsp_hold = 0;

      // Reset in the middle of an ACCESS phase.
      issue(0, 32'h0000_4000, $urandom, 4'hF, 3'b000, 50, 0, $urandom, 0);
      n = 0;
      while (!penable && n < 20) begin
         @(negedge pclk);
         n++;
      end
      chk("reset_test_in_access", penable, 1);
      @(negedge pclk);
      preset = 1'b1;
      @(negedge pclk);
      chk("midrst_psel", psel, 0);
      chk("midrst_penable", penable, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_cmd_ready", cmd_ready, 0);
      preset = 1'b0;
      @(negedge pclk);
      chk("midrst_cmd_ready_release", cmd_ready, 1);

      for (int k = 0; k < 60; k++) begin
         logic [31:0] a;
         int          w;
         a = ($urandom & ~32'h0000_7000) | (32'($urandom % 8) << 12);
         w = ($urandom % 5 == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 3));
         issue(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), w,
               1'($urandom), $urandom, 1);
      end

      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge pclk);
         n++;
      end
      chk("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", passes, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
